// File: rtl/mix_pkg.sv
// Shared sample width, mixer identity value and scheduler state encoding
// for the voice mixing tree.
package mix_pkg;

    localparam int SAMPLE_W = 18;
    localparam logic [SAMPLE_W-1:0] SILENCE = 18'h20000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mix_tag_pipe.sv
// Fixed-depth delay line carrying {valid, destination slot} alongside the
// external mixer so results can be written back without a mixer-side valid.
module mix_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] out_data
);

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_data = stage_q[DEPTH-1];

endmodule

// File: rtl/voice_mix_sched.sv
// Schedules a binary-tree reduction of NVOICE voice samples through one
// shared, fixed-latency two-input mixer, one reduction per sample tick.
module voice_mix_sched
    import mix_pkg::*;
#(
    parameter int NVOICE  = 8,
    parameter int MIX_LAT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_tick,
    input  logic [NVOICE*SAMPLE_W-1:0]   voice_data,
    input  logic [NVOICE-1:0]            voice_en,
    output logic [SAMPLE_W-1:0]          mix_a,
    output logic [SAMPLE_W-1:0]          mix_b,
    input  logic [SAMPLE_W-1:0]          mix_z,
    output logic [SAMPLE_W-1:0]          out_sample,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         ovr
);

    localparam int IDX_W = $clog2(NVOICE);
    localparam logic [IDX_W-1:0] LAST_LEVEL = IDX_W'(IDX_W - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    level_q, level_d;
    logic [IDX_W-1:0]    pair_q, pair_d;
    logic [SAMPLE_W-1:0] slot_q [NVOICE];
    logic [SAMPLE_W-1:0] slot_d [NVOICE];
    logic [SAMPLE_W-1:0] voice_w [NVOICE];
    logic [SAMPLE_W-1:0] out_sample_q, out_sample_d;
    logic                out_valid_q, out_valid_d;

    logic                issue;
    logic [IDX_W-1:0]    last_pair;
    logic [IDX_W-1:0]    idx_a, idx_b;
    logic [IDX_W:0]      tag_in, tag_out;
    logic                tag_vld;
    logic [IDX_W-1:0]    tag_dst;

    for (genvar gi = 0; gi < NVOICE; gi++) begin : g_voice
        assign voice_w[gi] = voice_data[gi*SAMPLE_W +: SAMPLE_W];
    end

    // Level L holds NVOICE >> (L+1) pairs; pair j reads slots 2j and 2j+1.
    assign last_pair = IDX_W'((NVOICE >> (int'(level_q) + 1)) - 1);
    assign idx_a     = IDX_W'({pair_q, 1'b0});
    assign idx_b     = idx_a | IDX_W'(1);

    assign issue = (state_q == ST_ISSUE) && !rst;
    assign mix_a = issue ? slot_q[idx_a] : SILENCE;
    assign mix_b = issue ? slot_q[idx_b] : SILENCE;

    assign busy = (state_q != ST_IDLE);
    assign ovr  = sample_tick && busy && !rst;

    assign tag_in  = {issue, pair_q};
    assign tag_vld = tag_out[IDX_W];
    assign tag_dst = tag_out[IDX_W-1:0];

    mix_tag_pipe #(
        .DEPTH (MIX_LAT),
        .W     (IDX_W + 1)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_data  (tag_in),
        .out_data (tag_out)
    );

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        pair_d       = pair_q;
        out_sample_d = out_sample_q;
        out_valid_d  = 1'b0;
        for (int i = 0; i < NVOICE; i++) begin
            slot_d[i] = slot_q[i];
        end

        if (tag_vld) begin
            slot_d[tag_dst] = mix_z;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    for (int i = 0; i < NVOICE; i++) begin
                        slot_d[i] = voice_en[i] ? voice_w[i] : SILENCE;
                    end
                    level_d = '0;
                    pair_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (pair_q == last_pair) begin
                    pair_d  = '0;
                    state_d = ST_DRAIN;
                end else begin
                    pair_d = pair_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                // The level is complete once its highest-numbered pair lands.
                if (tag_vld && (tag_dst == last_pair)) begin
                    if (level_q == LAST_LEVEL) begin
                        out_sample_d = mix_z;
                        out_valid_d  = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        level_d = level_q + IDX_W'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            level_q      <= '0;
            pair_q       <= '0;
            out_sample_q <= SILENCE;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            pair_q       <= pair_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NVOICE; i++) begin
            slot_q[i] <= slot_d[i];
        end
    end

    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_voice_mix_sched.sv
// Bench for voice_mix_sched with an offset-binary behavioural mixer of latency 3.
module tb_voice_mix_sched;
    import mix_pkg::*;

    localparam int NV      = 8;
    localparam int LAT     = 3;
    localparam int LEN_MAX = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sample_tick = 1'b0;
    logic [NV*18-1:0] voice_data = '0;
    logic [NV-1:0]    voice_en = '0;
    logic [17:0]      mix_a, mix_b, mix_z, out_sample;
    logic             out_valid, busy, ovr;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    voice_mix_sched #(
        .NVOICE  (NV),
        .MIX_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .voice_data  (voice_data),
        .voice_en    (voice_en),
        .mix_a       (mix_a),
        .mix_b       (mix_b),
        .mix_z       (mix_z),
        .out_sample  (out_sample),
        .out_valid   (out_valid),
        .busy        (busy),
        .ovr         (ovr)
    );

    // Offset-binary sum: SILENCE is the identity, wraps modulo 2^18.
    function automatic logic [17:0] mixf(input logic [17:0] a, input logic [17:0] b);
        return a + b - SILENCE;
    endfunction

    logic [17:0] zp [LAT];
    always @(posedge clk) begin
        zp[0] <= mixf(mix_a, mix_b);
        for (int i = 1; i < LAT; i++) zp[i] <= zp[i-1];
    end
    assign mix_z = zp[LAT-1];

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_scenario(input string name, input int len, input int nt,
                                input int t0, input int t1, input int t2, input int rst_c,
                                input logic [NV*18-1:0] d0, input logic [NV*18-1:0] d1,
                                input logic [NV*18-1:0] d2,
                                input logic [NV-1:0] e0, input logic [NV-1:0] e1,
                                input logic [NV-1:0] e2);
        logic [17:0]      ea [LEN_MAX];
        logic [17:0]      eb [LEN_MAX];
        logic [17:0]      sl [NV];
        logic [17:0]      nx [NV];
        logic [17:0]      res, exp_out;
        logic [NV*18-1:0] dcur;
        logic [NV-1:0]    ecur;
        bit               active, tick_now, rst_now, valid_exp, busy_exp, ovr_exp;
        int               done, s, n_acc, n_res;

        // Reset and check the idle state.
        @(posedge clk); #1;
        rst = 1'b1; sample_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk({name, " rst out_sample"}, out_sample, SILENCE);
        chk({name, " rst busy"}, 18'(busy), 18'd0);
        chk({name, " rst out_valid"}, 18'(out_valid), 18'd0);
        chk({name, " rst ovr"}, 18'(ovr), 18'd0);
        chk({name, " rst mix_a"}, mix_a, SILENCE);
        @(posedge clk); #1;

        for (int i = 0; i < LEN_MAX; i++) begin ea[i] = SILENCE; eb[i] = SILENCE; end
        active = 0; done = -1; res = SILENCE; exp_out = SILENCE; n_acc = 0; n_res = 0;

        for (int c = 0; c < len; c++) begin
            tick_now = 0; dcur = d0; ecur = e0;
            if (nt > 0 && c == t0) begin tick_now = 1; dcur = d0; ecur = e0; end
            if (nt > 1 && c == t1) begin tick_now = 1; dcur = d1; ecur = e1; end
            if (nt > 2 && c == t2) begin tick_now = 1; dcur = d2; ecur = e2; end
            rst_now     = (c == rst_c);
            rst         = rst_now;
            sample_tick = tick_now;
            voice_data  = dcur;
            voice_en    = ecur;

            valid_exp = 0;
            if (active && c == done) begin
                valid_exp = 1; exp_out = res; active = 0; n_res++;
            end
            busy_exp = active;
            ovr_exp  = tick_now && busy_exp && !rst_now;
            if (rst_now) begin
                for (int i = c; i < LEN_MAX; i++) begin ea[i] = SILENCE; eb[i] = SILENCE; end
            end

            @(negedge clk);
            chk($sformatf("%s c%0d ovr", name, c), 18'(ovr), 18'(ovr_exp));
            chk($sformatf("%s c%0d mix_a", name, c), mix_a, ea[c]);
            chk($sformatf("%s c%0d mix_b", name, c), mix_b, eb[c]);
            if (!rst_now) begin
                chk($sformatf("%s c%0d busy", name, c), 18'(busy), 18'(busy_exp));
                chk($sformatf("%s c%0d out_valid", name, c), 18'(out_valid), 18'(valid_exp));
                chk($sformatf("%s c%0d out_sample", name, c), out_sample, exp_out);
            end

            if (rst_now) begin
                active = 0; exp_out = SILENCE;
            end else if (tick_now && !busy_exp) begin
                n_acc++;
                for (int i = 0; i < NV; i++) sl[i] = ecur[i] ? dcur[18*i +: 18] : SILENCE;
                s = c + 1;
                for (int p = NV / 2; p >= 1; p = p / 2) begin
                    for (int j = 0; j < p; j++) begin
                        if (s + j < LEN_MAX) begin
                            ea[s+j] = sl[2*j];
                            eb[s+j] = sl[2*j+1];
                        end
                        nx[j] = mixf(sl[2*j], sl[2*j+1]);
                    end
                    for (int j = 0; j < p; j++) sl[j] = nx[j];
                    s = s + p + LAT;
                end
                res = sl[0]; done = s; active = 1;
            end

            @(posedge clk); #1;
        end
        rst = 1'b0; sample_tick = 1'b0;
        $display("scenario %s: ticks accepted=%0d results=%0d last_out=%h",
                 name, n_acc, n_res, exp_out);
    endtask

    initial begin
        logic [NV*18-1:0] da, db, dc;
        logic [NV-1:0]    ea, eb, ec;
        int               t1, t2;

        for (int i = 0; i < NV; i++) da[18*i +: 18] = SILENCE;
        run_scenario("all_silence", 24, 1, 0, -1, -1, -1, da, da, da, '1, '1, '1);

        for (int i = 0; i < NV; i++) da[18*i +: 18] = 18'($urandom);
        da[18*3 +: 18] = 18'h30000;
        run_scenario("voice3_only", 24, 1, 0, -1, -1, -1, da, da, da, 8'h08, 8'h08, 8'h08);

        for (int i = 0; i < NV; i++) da[18*i +: 18] = 18'(18'h20001 + i);
        run_scenario("ramp_sched", 24, 1, 0, -1, -1, -1, da, da, da, '1, '1, '1);

        for (int i = 0; i < NV; i++) begin
            da[18*i +: 18] = 18'($urandom);
            db[18*i +: 18] = 18'($urandom);
            dc[18*i +: 18] = 18'($urandom);
        end
        run_scenario("overrun_c6", 26, 2, 0, 6, -1, -1, da, db, dc, '1, '1, '1);
        run_scenario("rst_c5", 32, 2, 0, 10, -1, 5, da, db, dc, 8'h5A, 8'hFF, 8'h00);
        run_scenario("back_to_back", 40, 2, 0, 17, -1, -1, da, db, dc, 8'hF0, 8'h0F, 8'h00);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NV; i++) begin
                da[18*i +: 18] = 18'($urandom);
                db[18*i +: 18] = 18'($urandom);
                dc[18*i +: 18] = 18'($urandom);
            end
            ea = 8'($urandom_range(0, 255));
            eb = 8'($urandom_range(0, 255));
            ec = 8'($urandom_range(0, 255));
            t1 = $urandom_range(1, 25);
            t2 = t1 + $urandom_range(1, 15);
            run_scenario($sformatf("random%0d", k), 60, 3, 0, t1, t2, -1,
                         da, db, dc, ea, eb, ec);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
